// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: operand/cascade request, result hand-off and debug override bundle
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cas_l;
  logic             cas_e;
  logic             cas_g;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [2:0]       dbg_sel;
  logic [2:0]       dbg_val;
  logic [CNT_W-1:0] cmp_count;
  modport master (
    output in_valid, a, b, cas_l, cas_e, cas_g, out_ready, dbg_sel, dbg_val,
    input  in_ready, out_valid, lt, eq, gt, cmp_count
  );
  modport slave (
    input  in_valid, a, b, cas_l, cas_e, cas_g, out_ready, dbg_sel, dbg_val,
    output in_ready, out_valid, lt, eq, gt, cmp_count
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-first chunked unsigned compare with early exit, cascade resolve and debug override
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  seq_magnitude_comparator_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] ra, rb, ra_n, rb_n;
  logic [2:0]       cas, cas_n, res, res_n, cas_res;
  logic [IW-1:0]    idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CHUNK-1:0] ca, cb;
  assign ca = ra[idx*CHUNK +: CHUNK];
  assign cb = rb[idx*CHUNK +: CHUNK];
  // cascade only matters for fully-equal operands; less wins over greater
  assign cas_res = cas[2] ? 3'b100 : cas[0] ? 3'b001 : 3'b010;
  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = state == DONE;
  assign bus.cmp_count = cnt;
  assign {bus.lt, bus.eq, bus.gt} = (bus.dbg_sel & bus.dbg_val) | (~bus.dbg_sel & res);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      cas   <= '0;
      idx   <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ra    <= ra_n;
      rb    <= rb_n;
      cas   <= cas_n;
      idx   <= idx_n;
      res   <= res_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    ra_n    = ra;
    rb_n    = rb;
    cas_n   = cas;
    idx_n   = idx;
    res_n   = res;
    cnt_n   = cnt;
    case (state)
      IDLE: if (bus.in_valid) begin
        ra_n    = bus.a;
        rb_n    = bus.b;
        cas_n   = {bus.cas_l, bus.cas_e, bus.cas_g};
        idx_n   = IW'(N - 1);
        state_n = RUN;
      end
      RUN: if (ca != cb) begin
        res_n   = ca < cb ? 3'b100 : 3'b001;
        state_n = DONE;
      end else if (idx == '0) begin
        res_n   = cas_res;
        state_n = DONE;
      end else begin
        idx_n = idx - 1'b1;
      end
      DONE: if (bus.out_ready) begin
        cnt_n   = cnt + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle successor to the 3-output (less / equal / greater) cascadable comparator slice.
- Compares two WIDTH-bit unsigned operands MSB-first, CHUNK bits per cycle, and stops early at the first differing chunk.
- Valid/ready handshakes on both sides.
- Cascade inputs resolve fully-equal operands.
- Per-output debug override muxes preserve the existing gate-level debug-injection scheme. Instantiated between the operand staging registers and the result consumers.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; N = WIDTH/CHUNK chunks.
- CNT_W, 16, width of the completed-comparison counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/cascade bundle valid.
- in_ready  out  1  block can accept a bundle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cas_l  in  1  cascade "less" from lower-significance block.
- cas_e  in  1  cascade "equal".
- cas_g  in  1  cascade "greater".
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- lt  out  1  A < B (after debug mux).
- eq  out  1  A == B (after debug mux).
- gt  out  1  A > B (after debug mux).
- dbg_sel  in  3  per-output override select; bit2=lt, bit1=eq, bit0=gt.
- dbg_val  in  3  override values, same bit order.
- cmp_count  out  CNT_W  number of results handed off, wraps.

Behaviour:
- Clocking and reset: one clock (clk). rst is asynchronous, active-high.
- While rst is high:
  - state=IDLE; internal result regs {lt,eq,gt}=000; out_valid=0; cmp_count=0.
  - in_ready=0, forced low by rst.
  - Debug-muxed outputs still follow dbg_sel/dbg_val.
- State machine, states IDLE, RUN, DONE:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: register a, b, cas_*; idx=N-1; go RUN.
  - RUN:
    - in_ready=0, out_valid=0.
    - Each cycle compares a[idx*CHUNK +: CHUNK] vs b[same] (unsigned).
    - If the chunks differ: latch lt/gt accordingly, eq=0, go DONE.
    - Else if idx==0: resolve from cascade, go DONE.
    - Else idx<=idx-1.
  - DONE:
    - out_valid=1; result regs held stable.
    - On out_valid&out_ready: cmp_count<=cmp_count+1 (wraps at 2^CNT_W), go IDLE.
    - in_ready=0 throughout DONE; no overlap of accept and hand-off.
- Cascade resolution applies only to fully-equal operands. Priority:
  - cas_l gives 100.
  - else cas_g gives 001.
  - else 010; this also covers cas_e=1 and the all-zero cascade.
- Exactly one of the internal lt/eq/gt is 1 whenever out_valid=1.
- Latency:
  - First difference in chunk N-1-j gives out_valid high j+1 cycles after the accepting edge.
  - Fully equal operands give N cycles.
  - Minimum 1, maximum N.
- Debug mux: output[i] = dbg_sel[i] ? dbg_val[i] : internal[i].
  - Purely combinational.
  - Does not affect the FSM, out_valid, in_ready or cmp_count.
  - Applies in every state, including reset.
- Outputs lt/eq/gt in IDLE/RUN show the last registered result (000 after reset). Consumers qualify with out_valid.
- Backpressure: DONE is held indefinitely while out_ready=0. in_valid during RUN/DONE is ignored and not queued.
- Reset mid-RUN/DONE: the comparison is aborted immediately; no hand-off occurs; the count is not incremented.
- Operand inputs may change freely after the accepting edge.

Test Plan: (WIDTH=8, CHUNK=2, N=4)
- a=8'hC0, b=8'h40, cas=000, out_ready=1 -> out_valid 1 cycle after accept; lt,eq,gt=0,0,1; cmp_count 0->1.
- a=8'h12, b=8'h13 -> differs only in chunk0; out_valid 4 cycles after accept; lt=1, eq=0, gt=0.
- a=b=8'h5A with cas_e=1 -> eq=1 after 4 cycles. Repeat with cas_g=1 -> gt=1. Repeat with cas_l=1,cas_g=1 -> lt=1 (priority).
- Backpressure: a=8'h01, b=8'h80, out_ready=0 for 5 cycles, in_valid held 1 with new operands -> outputs stay 100, in_ready=0, second bundle not taken until the cycle after the hand-off.
- Debug override: dbg_sel=3'b010, dbg_val=3'b010 during an a>b compare -> eq=1, gt=1 (gt unforced), out_valid/latency unchanged. dbg_sel=3'b111, dbg_val=3'b000 -> all outputs 0.
- Reset: assert rst during RUN on the 2nd cycle -> out_valid=0, cmp_count=0, in_ready=0 immediately. After release, in_ready=1 and the next compare completes normally.
